gray_counter_n: RTL and testbench
=================================

Name: gray_counter_n

Overview:
- Parametrised N-bit Gray-code counter that succeeds the fixed 3-bit up-only Gray counter.
- Adds up/down direction, synchronous load, an optional saturate mode, separate sticky overflow and underflow flags with a clear input, and a one-cycle wrap pulse.
- Used as the sequence source for state encoding, and as a pointer generator for later FIFO and clock-domain-crossing blocks.

Parameters:
- WIDTH, 3, counter width in bits; must be >= 2.
- SATURATE, 0: 0 = wrap at the ends of the range; 1 = hold at the end value.
- INIT, 0, binary value the count takes on reset.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- En  input  1  count enable; one step per enabled cycle.
- Dir  input  1  1 = count up, 0 = count down; sampled with En.
- Load  input  1  synchronous load of LoadVal.
- LoadVal  input  WIDTH  value to load, binary encoded.
- ClrFlag  input  1  synchronous clear of Overflow and Underflow.
- Output  output  WIDTH  current count, Gray encoded, registered.
- Binary  output  WIDTH  current count, binary encoded, registered.
- Overflow  output  1  sticky; set when an up-step leaves MAX = 2^WIDTH-1.
- Underflow  output  1  sticky; set when a down-step leaves 0.
- Wrap  output  1  one-cycle pulse on any overflow or underflow event.

Behaviour:
- State:
  - cnt is a WIDTH-bit binary register.
  - Output register always holds cnt ^ (cnt >> 1).
  - Binary = cnt.
  - Both outputs are registered and change only on a Clk edge or on Reset.
- Reset, asynchronous, takes effect immediately with no clock needed:
  - cnt = INIT, so Output = gray(INIT).
  - Overflow = 0, Underflow = 0, Wrap = 0.
- Per-edge priority when Reset = 0:
  1. Load=1: cnt <= LoadVal. En and Dir are ignored. No flag event.
  2. Else if En=1 and Dir=1:
     - cnt < MAX: cnt <= cnt+1.
     - cnt == MAX: overflow event. SATURATE=0 gives cnt <= 0; SATURATE=1 holds cnt at MAX.
  3. Else if En=1 and Dir=0:
     - cnt > 0: cnt <= cnt-1.
     - cnt == 0: underflow event. SATURATE=0 gives cnt <= MAX; SATURATE=1 holds cnt at 0.
  4. Else: hold.
- Flags:
  - An overflow event sets Overflow <= 1; an underflow event sets Underflow <= 1.
  - ClrFlag=1 clears both flags at the edge.
  - If ClrFlag and an event occur in the same cycle, the set wins for the flag that the event targets; the other flag clears.
  - Load does not modify the flags.
- Wrap:
  - Wrap <= 1 for exactly the cycle following an event edge, in both wrap and saturate modes.
  - Otherwise Wrap <= 0.
- Gray property: in wrap mode, each count step changes exactly one bit of Output, including the MAX<->0 transition.
- Latency: Output reflects a step, load or event one clock after the input is sampled.
- Dir change: takes effect on the next enabled edge; there is no dead cycle.
- Reset mid-operation: overrides any pending load or step. Flags and Wrap clear asynchronously.
- Load with LoadVal == cnt: legal; values are unchanged and no event occurs.

Decomposition:
- Package gray_pkg holds:
  - functions bin2gray(b) and gray2bin(g), parametrised by WIDTH;
  - a localparam helper for MAX;
  - the mode constants MODE_WRAP = 0 and MODE_SAT = 1.
- One combinational sub-module, gray_enc (binary to Gray, WIDTH param), feeds the Output register. It is reused later by FIFO pointer blocks.
- Next-state and flag logic stay in gray_counter_n.

Test Plan:
- Reset with WIDTH=3, INIT=0, then En=1, Dir=1 for 8 cycles:
  - Output sequence is 000,001,011,010,110,111,101,100,000.
  - Overflow rises on the 8th edge and stays high; Wrap pulses once.
  - Every step changes exactly one Output bit.
- From 0, En=1, Dir=0, SATURATE=0:
  - Output=100 and Binary=7.
  - Underflow=1 and Wrap pulses; Overflow stays 0.
- SATURATE=1, Load LoadVal=7, then 3 up-steps:
  - Binary holds at 7 and Output=100.
  - Overflow=1; Wrap pulses on each of the 3 edges.
- Load=1, LoadVal=5, En=1, Dir=1 in the same cycle:
  - Binary=5 and Output=111, with no increment.
  - Then ClrFlag=1 with En=0 clears both flags.
- At Binary=7 with Overflow=0, drive En=1, Dir=1, ClrFlag=1:
  - Overflow=1 because set wins; Binary=0.
- With Binary=4, assert Reset between clock edges:
  - Outputs go immediately to gray(INIT), with flags and Wrap at 0.
  - Counting resumes correctly after deassert.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and mode constants for the Gray counter family
// and the FIFO / clock-domain-crossing pointer blocks that reuse them.
package gray_pkg;

  localparam int GRAY_MAX_W = 64;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Operands are zero-extended to GRAY_MAX_W, so any width up to that limit works.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] max_count(input int width);
    return (GRAY_MAX_W'(1) << width) - GRAY_MAX_W'(1);
  endfunction

endpackage

// File: rtl/gray_enc.sv
// Combinational binary-to-Gray encoder.
module gray_enc #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter_n.sv
// N-bit up/down Gray counter with load, optional saturation, sticky
// overflow/underflow flags and a one-cycle wrap pulse.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int          WIDTH    = 3,
  parameter int          SATURATE = MODE_WRAP,
  parameter int unsigned INIT     = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             ClrFlag,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Wrap
);

  localparam logic [GRAY_MAX_W-1:0] MAX_W       = max_count(WIDTH);
  localparam logic [WIDTH-1:0]      MAX         = MAX_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0]      INIT_BIN    = WIDTH'(INIT);
  localparam logic [GRAY_MAX_W-1:0] INIT_GRAY_W = bin2gray(GRAY_MAX_W'(INIT_BIN));
  localparam logic [WIDTH-1:0]      INIT_GRAY   = INIT_GRAY_W[WIDTH-1:0];

  if (WIDTH < 2 || WIDTH > GRAY_MAX_W) begin : g_bad_width
    $error("gray_counter_n: WIDTH out of range");
  end

  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] gray_reg, gray_next;
  logic             ovf_reg, ovf_next;
  logic             unf_reg, unf_next;
  logic             wrap_reg;
  logic             ovf_evt, unf_evt;

  assign ovf_evt = !Load && En &&  Dir && (cnt_reg == MAX);
  assign unf_evt = !Load && En && !Dir && (cnt_reg == '0);

  always_comb begin
    cnt_next = cnt_reg;
    if (Load) begin
      cnt_next = LoadVal;
    end else if (En && Dir) begin
      if (ovf_evt) cnt_next = (SATURATE == MODE_SAT) ? MAX : '0;
      else         cnt_next = cnt_reg + WIDTH'(1);
    end else if (En) begin
      if (unf_evt) cnt_next = (SATURATE == MODE_SAT) ? '0 : MAX;
      else         cnt_next = cnt_reg - WIDTH'(1);
    end
  end

  // An event in the same cycle as ClrFlag keeps its own flag set.
  always_comb begin
    ovf_next = ovf_reg && !ClrFlag;
    unf_next = unf_reg && !ClrFlag;
    if (ovf_evt) ovf_next = 1'b1;
    if (unf_evt) unf_next = 1'b1;
  end

  // Encoding the next count keeps Output registered and aligned with Binary.
  gray_enc #(.WIDTH(WIDTH)) u_gray_enc (
    .bin  (cnt_next),
    .gray (gray_next)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_reg  <= INIT_BIN;
      gray_reg <= INIT_GRAY;
      ovf_reg  <= 1'b0;
      unf_reg  <= 1'b0;
      wrap_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      gray_reg <= gray_next;
      ovf_reg  <= ovf_next;
      unf_reg  <= unf_next;
      wrap_reg <= ovf_evt || unf_evt;
    end
  end

  assign Output    = gray_reg;
  assign Binary    = cnt_reg;
  assign Overflow  = ovf_reg;
  assign Underflow = unf_reg;
  assign Wrap      = wrap_reg;

endmodule

// File: tb/tb_gray_counter_n.sv
// Bench for gray_counter_n: a wrapping and a saturating instance share stimulus
// and are compared every cycle against a behavioural model.
module tb_gray_counter_n;

  localparam int W    = 3;
  localparam int MAXV = 7;

  logic         Clk = 1'b0;
  logic         Reset, En, Dir, Load, ClrFlag;
  logic [W-1:0] LoadVal;
  logic [W-1:0] out_w, bin_w, out_s, bin_s;
  logic         ovf_w, unf_w, wrap_w, ovf_s, unf_s, wrap_s;

  int checks = 0;
  int fails  = 0;

  // Model state, index 0 = wrap instance, 1 = saturate instance.
  int m_cnt [2];
  bit m_ovf [2];
  bit m_unf [2];
  bit m_wrap[2];

  logic [W-1:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                 3'b110, 3'b111, 3'b101, 3'b100};

  always #5 Clk = ~Clk;

  gray_counter_n #(.WIDTH(W), .SATURATE(0), .INIT(0)) dut_wrap (
    .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load),
    .LoadVal(LoadVal), .ClrFlag(ClrFlag), .Output(out_w), .Binary(bin_w),
    .Overflow(ovf_w), .Underflow(unf_w), .Wrap(wrap_w)
  );

  gray_counter_n #(.WIDTH(W), .SATURATE(1), .INIT(0)) dut_sat (
    .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load),
    .LoadVal(LoadVal), .ClrFlag(ClrFlag), .Output(out_s), .Binary(bin_s),
    .Overflow(ovf_s), .Underflow(unf_s), .Wrap(wrap_s)
  );

  function automatic logic [2*W+2:0] expv(int s);
    return {gray_tab[m_cnt[s]], W'(m_cnt[s]), m_ovf[s], m_unf[s], m_wrap[s]};
  endfunction

  function automatic logic [2*W+2:0] obsv(int s);
    if (s == 0) return {out_w, bin_w, ovf_w, unf_w, wrap_w};
    return {out_s, bin_s, ovf_s, unf_s, wrap_s};
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0; m_ovf[s] = 0; m_unf[s] = 0; m_wrap[s] = 0;
    end
  endfunction

  function automatic void model_edge(bit ld, int lv, bit en, bit dir, bit clr);
    for (int s = 0; s < 2; s++) begin
      bit ev_o = 0, ev_u = 0;
      if (ld) m_cnt[s] = lv;
      else if (en && dir) begin
        if (m_cnt[s] == MAXV) begin ev_o = 1; m_cnt[s] = (s == 1) ? MAXV : 0; end
        else m_cnt[s]++;
      end else if (en) begin
        if (m_cnt[s] == 0) begin ev_u = 1; m_cnt[s] = (s == 1) ? 0 : MAXV; end
        else m_cnt[s]--;
      end
      if (clr) begin m_ovf[s] = 0; m_unf[s] = 0; end
      if (ev_o) m_ovf[s] = 1;
      if (ev_u) m_unf[s] = 1;
      m_wrap[s] = ev_o | ev_u;
    end
  endfunction

  task automatic step(bit ld, int lv, bit en, bit dir, bit clr);
    Load = ld; LoadVal = W'(lv); En = en; Dir = dir; ClrFlag = clr;
    @(posedge Clk);
    model_edge(ld, lv, en, dir, clr);
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    Reset = 1'b1; En = 0; Dir = 0; Load = 0; LoadVal = '0; ClrFlag = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (obsv(s) !== expv(s)) begin
        fails++;
        $display("FAIL reset[%0d]: got %b required %b", s, obsv(s), expv(s));
      end
    end
    Reset = 1'b0;
  endtask

  task automatic test_count_up();
    logic [W-1:0] prev;
    int wraps = 0;
    for (int i = 0; i < 8; i++) begin
      prev = out_w;
      step(0, 0, 1, 1, 0);
      wraps += int'(wrap_w);
      checks++;
      if (out_w !== gray_tab[(i + 1) % 8] || $countones(out_w ^ prev) != 1) begin
        fails++;
        $display("FAIL up_seq step %0d: got %b (prev %b) required %b", i, out_w, prev, gray_tab[(i+1)%8]);
      end
      for (int s = 0; s < 2; s++) begin
        checks++;
        if (obsv(s) !== expv(s)) begin
          fails++;
          $display("FAIL up_model[%0d] step %0d: got %b required %b", s, i, obsv(s), expv(s));
        end
      end
    end
    step(0, 0, 0, 1, 0);
    checks++;
    if (ovf_w !== 1'b1 || wraps != 1 || wrap_w !== 1'b0) begin
      fails++;
      $display("FAIL up_flags: got ovf=%b wraps=%0d wrap=%b required ovf=1 wraps=1 wrap=0", ovf_w, wraps, wrap_w);
    end
  endtask

  task automatic test_count_down();
    pulse_reset();
    step(0, 0, 1, 0, 0);
    checks++;
    if ({out_w, bin_w, unf_w, wrap_w, ovf_w} !== {3'b100, 3'd7, 1'b1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL down_wrap: got out=%b bin=%0d unf=%b wrap=%b ovf=%b required 100 7 1 1 0", out_w, bin_w, unf_w, wrap_w, ovf_w);
    end
    checks++;
    if (obsv(1) !== expv(1)) begin
      fails++;
      $display("FAIL down_sat: got %b required %b", obsv(1), expv(1));
    end
  endtask

  task automatic test_saturate();
    pulse_reset();
    step(1, 7, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 0);
      checks++;
      if ({bin_s, out_s, ovf_s, wrap_s} !== {3'd7, 3'b100, 1'b1, 1'b1}) begin
        fails++;
        $display("FAIL sat_hold edge %0d: got bin=%0d out=%b ovf=%b wrap=%b required 7 100 1 1", i, bin_s, out_s, ovf_s, wrap_s);
      end
      checks++;
      if (obsv(0) !== expv(0)) begin
        fails++;
        $display("FAIL sat_wrapinst edge %0d: got %b required %b", i, obsv(0), expv(0));
      end
    end
  endtask

  task automatic test_load_priority();
    step(1, 5, 1, 1, 0);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (obsv(s) !== expv(s) || obsv(s)[2*W+2:3] !== {3'b111, 3'd5}) begin
        fails++;
        $display("FAIL load_prio[%0d]: got %b required %b", s, obsv(s), expv(s));
      end
    end
    step(0, 0, 0, 1, 1);
    checks++;
    if ({ovf_w, unf_w, ovf_s, unf_s} !== 4'b0000 || bin_w !== 3'd5) begin
      fails++;
      $display("FAIL clr_flags: got flags=%b%b%b%b bin=%0d required 0000 5", ovf_w, unf_w, ovf_s, unf_s, bin_w);
    end
  endtask

  task automatic test_clr_set_wins();
    step(1, 7, 0, 0, 0);
    step(0, 0, 1, 1, 1);
    checks++;
    if ({ovf_w, bin_w, wrap_w} !== {1'b1, 3'd0, 1'b1}) begin
      fails++;
      $display("FAIL clr_set_wins: got ovf=%b bin=%0d wrap=%b required 1 0 1", ovf_w, bin_w, wrap_w);
    end
    checks++;
    if (obsv(1) !== expv(1)) begin
      fails++;
      $display("FAIL clr_set_wins_sat: got %b required %b", obsv(1), expv(1));
    end
  endtask

  task automatic test_async_reset();
    step(1, 4, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    model_reset();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (obsv(s) !== expv(s)) begin
        fails++;
        $display("FAIL async_reset[%0d]: got %b required %b", s, obsv(s), expv(s));
      end
    end
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (obsv(s) !== expv(s)) begin
        fails++;
        $display("FAIL after_reset[%0d]: got %b required %b", s, obsv(s), expv(s));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 7) == 0, int'($urandom_range(0, MAXV)),
           $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0);
      for (int s = 0; s < 2; s++) begin
        checks++;
        if (obsv(s) !== expv(s)) begin
          fails++;
          $display("FAIL random[%0d] cycle %0d: got %b required %b", s, i, obsv(s), expv(s));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_load_priority();
    test_clr_set_wins();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
